fp_unpack_pipe: RTL and testbench

//   Registered, parametrised multi-lane FP operand unpacker for the DP datapath front end.

---
 rtl/fp_unpack_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp_unpack_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unpack_pipe.sv
// ---------------------------------------------------------------------------
// fp_unpack_pipe
//
// Registered multi-lane FP operand unpacker for the DP datapath front end.
// Each lane's packed half or single operand is split into a sign, an 8-bit
// biased exponent and two SPLIT_W-bit mantissa halves, and is classified as
// normal/subnormal, zero, inf or NaN. The hidden bit sits just above the
// stored fraction in the half that carries the fraction's top bit.
//
// Handshake: a beat transfers on an interface when valid & ready are both 1
// at a rising clk edge. The producer holds valid and data steady until the
// transfer happens. ready never depends on valid in the same cycle.
//
// Storage is an output register (OR) plus one skid register (SK). in_ready
// comes straight from the SK valid flop, so there is no combinational path
// from in_valid or out_ready to in_ready. Latency is one cycle and
// throughput is one beat per clock while out_ready stays high.
//
// Optional feature (compile-time macro FP_UNPACK_SUBNORM_EN):
//   defined   - subnormals keep their fraction with hidden bit 0 and report
//               exponent 8'h01 and class 00.
//   undefined - subnormals flush to zero: exp/high/low 0, class 01, sign kept.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       input beat valid
//   in_ready       block can accept a beat
//   in_mode        1 = half operands, 0 = single operands
//   in_data        LANES*IN_W packed operands, lane i = in_data[i*32 +: 32]
//   out_valid      output beat valid
//   out_ready      consumer accepts output beat
//   out_mode       in_mode of the beat on the outputs
//   out_sign       per-lane sign
//   out_exp        per-lane biased exponent (8 bits per lane)
//   out_high       per-lane upper mantissa half
//   out_low        per-lane lower mantissa half
//   out_class      per lane: 00 normal/subnormal, 01 zero, 10 inf, 11 NaN
// ---------------------------------------------------------------------------
module fp_unpack_pipe #(
    parameter int LANES   = 8,
    parameter int IN_W    = 32,
    parameter int SPLIT_W = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [LANES*IN_W-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_mode,
    output logic [LANES-1:0]           out_sign,
    output logic [LANES*8-1:0]         out_exp,
    output logic [LANES*SPLIT_W-1:0]   out_high,
    output logic [LANES*SPLIT_W-1:0]   out_low,
    output logic [LANES*2-1:0]         out_class
);

    // One unpacked lane: {sign, exp[7:0], high, low, class[1:0]}
    localparam int LW = 2*SPLIT_W + 11;
    // One full beat: {mode, signs, exps, highs, lows, classes}
    localparam int BW = 1 + LANES*LW;

    function automatic logic [LW-1:0] unpack_lane(input logic [IN_W-1:0] d,
                                                  input logic            half);
        logic               s;
        logic [7:0]         e;
        logic [7:0]         e_max;
        logic [9:0]         f_hi;
        logic [12:0]        f_lo;
        logic               h;
        logic               f_nz;
        logic               subn;
        logic [SPLIT_W-1:0] hi;
        logic [SPLIT_W-1:0] lo;
        logic [1:0]         c;

        if (half) begin
            // Upper 16 bits of the lane are don't-care in half mode.
            s     = d[15];
            e     = {3'b000, d[14:10]};
            e_max = 8'h1F;
            f_hi  = '0;
            f_lo  = {3'b000, d[9:0]};
        end else begin
            s     = d[31];
            e     = d[30:23];
            e_max = 8'hFF;
            f_hi  = d[22:13];
            f_lo  = d[12:0];
        end

        h    = (e != 8'h00);
        f_nz = (f_hi != 10'h000) || (f_lo != 13'h0000);
        subn = !h && f_nz;

        // Hidden bit goes directly above the fraction's top bit.
        hi = '0;
        lo = '0;
        if (half) begin
            lo[10:0] = {h, f_lo[9:0]};
        end else begin
            hi[10:0] = {h, f_hi};
            lo[12:0] = f_lo;
        end

        if (!h && !f_nz) begin
            c = 2'b01;
        end else if (e == e_max) begin
            c = f_nz ? 2'b11 : 2'b10;
        end else begin
            c = 2'b00;
        end

`ifdef FP_UNPACK_SUBNORM_EN
        // Subnormal: effective exponent is 1, fraction kept with h = 0.
        if (subn) begin
            e = 8'h01;
        end
`else
        // Flush subnormals to a signed zero.
        if (subn) begin
            hi = '0;
            lo = '0;
            c  = 2'b01;
        end
`endif

        return {s, e, hi, lo, c};
    endfunction

    logic [LW-1:0]            lane_v [LANES];
    logic [LANES-1:0]         u_sign;
    logic [LANES*8-1:0]       u_exp;
    logic [LANES*SPLIT_W-1:0] u_high;
    logic [LANES*SPLIT_W-1:0] u_low;
    logic [LANES*2-1:0]       u_class;
    logic [BW-1:0]            u_beat;

    always_comb begin
        u_sign  = '0;
        u_exp   = '0;
        u_high  = '0;
        u_low   = '0;
        u_class = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_v[i]                   = unpack_lane(in_data[i*IN_W +: IN_W], in_mode);
            u_class[i*2 +: 2]           = lane_v[i][1:0];
            u_low[i*SPLIT_W +: SPLIT_W]  = lane_v[i][2 +: SPLIT_W];
            u_high[i*SPLIT_W +: SPLIT_W] = lane_v[i][SPLIT_W+2 +: SPLIT_W];
            u_exp[i*8 +: 8]             = lane_v[i][2*SPLIT_W+2 +: 8];
            u_sign[i]                   = lane_v[i][2*SPLIT_W+10];
        end
    end

    assign u_beat = {in_mode, u_sign, u_exp, u_high, u_low, u_class};

    // ------------------------------------------------------------------
    // OR + SK storage. sk_valid implies or_valid: SK only fills while OR
    // is held, and SK always moves into OR before OR can empty.
    // ------------------------------------------------------------------
    logic          or_valid;
    logic          sk_valid;
    logic [BW-1:0] or_beat;
    logic [BW-1:0] sk_beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_beat  <= '0;
            sk_beat  <= '0;
        end else if (sk_valid) begin
            // in_ready is 0 here, so no input can be taken this cycle.
            if (out_ready) begin
                or_beat  <= sk_beat;
                sk_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!or_valid || out_ready) begin
                or_beat  <= u_beat;
                or_valid <= 1'b1;
            end else begin
                sk_beat  <= u_beat;
                sk_valid <= 1'b1;
            end
        end else if (out_ready) begin
            or_valid <= 1'b0;
        end
    end

    assign in_ready  = !sk_valid;
    assign out_valid = or_valid;
    assign {out_mode, out_sign, out_exp, out_high, out_low, out_class} = or_beat;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
module tb_fp_unpack_pipe;

  localparam int LANES = 8;
  localparam int SW    = 13;
  localparam int BW    = 1 + LANES*(2*SW + 11);

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [LANES*32-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_mode;
  logic [LANES-1:0]      out_sign;
  logic [LANES*8-1:0]    out_exp;
  logic [LANES*SW-1:0]   out_high;
  logic [LANES*SW-1:0]   out_low;
  logic [LANES*2-1:0]    out_class;

  logic [BW-1:0]         act_beat;
  logic [BW-1:0]         exp_b;
  logic [BW-1:0]         exp_q[$];
  int                    check_cnt;
  int                    pass_cnt;

  fp_unpack_pipe #(.LANES(LANES), .IN_W(32), .SPLIT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_high  (out_high),
    .out_low   (out_low),
    .out_class (out_class)
  );

  assign act_beat = {out_mode, out_sign, out_exp, out_high, out_low, out_class};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Builds the expected beat from the IEEE meaning of each operand:
  // full significand {hidden, fraction}, split into 13-bit halves.
  function automatic logic [BW-1:0] model_beat(input logic [LANES*32-1:0] d, input logic m);
    logic [LANES-1:0]    s;
    logic [LANES*8-1:0]  e;
    logic [LANES*SW-1:0] hi;
    logic [LANES*SW-1:0] lo;
    logic [LANES*2-1:0]  c;
    logic [31:0]         w;
    logic [7:0]          ex;
    logic [7:0]          top;
    logic [22:0]         fr;
    logic [23:0]         sig;
    logic [12:0]         h_v;
    logic [12:0]         l_v;
    logic [1:0]          c_v;
    for (int i = 0; i < LANES; i++) begin
      w = d[i*32 +: 32];
      if (m) begin
        s[i] = w[15]; ex = {3'b000, w[14:10]}; fr = {13'b0, w[9:0]}; top = 8'h1F;
      end else begin
        s[i] = w[31]; ex = w[30:23]; fr = w[22:0]; top = 8'hFF;
      end
      if (m) begin
        sig = {13'b0, (ex != 8'h00), w[9:0]};
        h_v = 13'h0000;
        l_v = sig[12:0];
      end else begin
        sig = {(ex != 8'h00), fr};
        h_v = {2'b00, sig[23:13]};
        l_v = sig[12:0];
      end
      if (ex == top)      c_v = (fr == 23'h0) ? 2'b10 : 2'b11;
      else if (ex != 0)   c_v = 2'b00;
      else if (fr == 0)   c_v = 2'b01;
      else begin
`ifdef FP_UNPACK_SUBNORM_EN
        ex = 8'h01; c_v = 2'b00;
`else
        h_v = 13'h0000; l_v = 13'h0000; c_v = 2'b01;
`endif
      end
      e[i*8 +: 8]   = ex;
      hi[i*SW +: SW] = h_v;
      lo[i*SW +: SW] = l_v;
      c[i*2 +: 2]   = c_v;
    end
    return {m, s, e, hi, lo, c};
  endfunction

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: inputs/outputs are stable until the next
  // rising edge, where the transfers below actually happen.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_underflow: got beat %h with empty expected queue", act_beat);
        end else begin
          exp_b = exp_q.pop_front();
          if (act_beat !== exp_b) $display("FAIL sb_beat: got %h expected %h", act_beat, exp_b);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_beat(in_data, in_mode));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [LANES*32-1:0] mk(input logic [31:0] l0);
    logic [LANES*32-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
    r[31:0] = l0;
    return r;
  endfunction

  function automatic logic [31:0] rnd_lane(input logic m);
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 4);
    if (m) begin
      case (sel)
        0: w[14:10] = 5'h00;
        1: w[14:10] = 5'h1F;
        2: w[14:0]  = 15'h7C00;
        3: w[14:0]  = 15'h0000;
        default: ;
      endcase
    end else begin
      case (sel)
        0: w[30:23] = 8'h00;
        1: w[30:23] = 8'hFF;
        2: w[30:0]  = 31'h7F800000;
        3: w[30:0]  = 31'h0;
        default: ;
      endcase
    end
    return w;
  endfunction

  // Drive one beat (caller ensures in_ready=1), return at the falling edge
  // after the accepting rising edge so the result is on out_*.
  task automatic apply(input logic [LANES*32-1:0] d, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = mk(32'h3F800000); out_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    check_cnt++; if (act_beat !== '0) $display("FAIL reset_data: got %h want 0", act_beat); else pass_cnt++;
    next_cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_1p5();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = mk(32'h3FC00000); in_mode = 1'b0;
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL s15_pre_valid: got %b want 0", out_valid); else pass_cnt++;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL s15_latency: out_valid got %b want 1", out_valid); else pass_cnt++;
    check_cnt++;
    if ({out_mode, out_sign[0], out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]} !== {1'b0, 1'b0, 8'h7F, 13'h0600, 13'h0000, 2'b00})
      $display("FAIL s15_fields: got m%b s%b e%h h%h l%h c%b want m0 s0 e7f h0600 l0000 c00",
               out_mode, out_sign[0], out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_half_neg1();
    logic [LANES*32-1:0] d;
    d = mk(32'h0000BC00);
    d[63:32] = 32'hFFFF3C00; // upper half garbage must be ignored
    apply(d, 1'b1);
    check_cnt++;
    if ({out_mode, out_sign[0], out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]} !== {1'b1, 1'b1, 8'h0F, 13'h0000, 13'h0400, 2'b00})
      $display("FAIL half_m1: got m%b s%b e%h h%h l%h c%b want m1 s1 e0f h0000 l0400 c00",
               out_mode, out_sign[0], out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]);
    else pass_cnt++;
    check_cnt++;
    if ({out_sign[1], out_exp[15:8], out_low[25:13]} !== {1'b0, 8'h0F, 13'h0400})
      $display("FAIL half_upper_ignored: got s%b e%h l%h want s0 e0f l0400", out_sign[1], out_exp[15:8], out_low[25:13]);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_specials();
    logic [LANES*32-1:0] d;
    d = mk(32'h7F800000);
    d[63:32] = 32'h7FC00000;
    d[95:64] = 32'h80000000;
    apply(d, 1'b0);
    check_cnt++; if (out_class[1:0] !== 2'b10) $display("FAIL sp_inf: got %b want 10", out_class[1:0]); else pass_cnt++;
    check_cnt++; if (out_class[3:2] !== 2'b11) $display("FAIL sp_nan: got %b want 11", out_class[3:2]); else pass_cnt++;
    check_cnt++;
    if ({out_class[5:4], out_sign[2]} !== {2'b01, 1'b1})
      $display("FAIL sp_negzero: got c%b s%b want c01 s1", out_class[5:4], out_sign[2]);
    else pass_cnt++;
    next_cycle();
    d = mk(32'h00007C01);
    d[63:32] = 32'h00007C00;
    apply(d, 1'b1);
    check_cnt++; if (out_class[1:0] !== 2'b11) $display("FAIL sp_half_nan: got %b want 11", out_class[1:0]); else pass_cnt++;
    check_cnt++; if (out_class[3:2] !== 2'b10) $display("FAIL sp_half_inf: got %b want 10", out_class[3:2]); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_subnormal();
    logic [LANES*32-1:0] d;
    d = mk(32'h00000001);
    d[63:32] = 32'h80000001;
    apply(d, 1'b0);
`ifdef FP_UNPACK_SUBNORM_EN
    check_cnt++;
    if ({out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]} !== {8'h01, 13'h0000, 13'h0001, 2'b00})
      $display("FAIL subn_single: got e%h h%h l%h c%b want e01 h0000 l0001 c00", out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]);
    else pass_cnt++;
    check_cnt++;
    if ({out_sign[1], out_exp[15:8], out_class[3:2]} !== {1'b1, 8'h01, 2'b00})
      $display("FAIL subn_neg: got s%b e%h c%b want s1 e01 c00", out_sign[1], out_exp[15:8], out_class[3:2]);
    else pass_cnt++;
`else
    check_cnt++;
    if ({out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]} !== {8'h00, 13'h0000, 13'h0000, 2'b01})
      $display("FAIL subn_single: got e%h h%h l%h c%b want e00 h0000 l0000 c01", out_exp[7:0], out_high[12:0], out_low[12:0], out_class[1:0]);
    else pass_cnt++;
    check_cnt++;
    if ({out_sign[1], out_exp[15:8], out_class[3:2]} !== {1'b1, 8'h00, 2'b01})
      $display("FAIL subn_neg: got s%b e%h c%b want s1 e00 c01", out_sign[1], out_exp[15:8], out_class[3:2]);
    else pass_cnt++;
`endif
    next_cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_mode = k[0]; in_data = mk(rnd_lane(k[0]));
      @(negedge clk);
      check_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", k, in_ready); else pass_cnt++;
      if (k > 0) begin
        check_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b want 1", k, out_valid); else pass_cnt++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_last: got %b want 1", out_valid); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_mode = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h3F800001);              // A
    next_cycle();
    in_data = mk(32'h3F800002);                                // B
    next_cycle();
    in_data = mk(32'h3F800003);                                // C
    @(negedge clk);
    check_cnt++; if ({out_valid, out_low[12:0]} !== {1'b1, 13'h0001}) $display("FAIL bp_hold_a: got v%b l%h want v1 l0001", out_valid, out_low[12:0]); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_skid_full: in_ready got %b want 0", in_ready); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    check_cnt++; if ({out_valid, out_low[12:0]} !== {1'b1, 13'h0001}) $display("FAIL bp_stable_a: got v%b l%h want v1 l0001", out_valid, out_low[12:0]); else pass_cnt++;
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check_cnt++; if (out_low[12:0] !== 13'h0002) $display("FAIL bp_order_b: got l%h want l0002", out_low[12:0]); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else pass_cnt++;
    next_cycle();
    in_data = mk(32'h3F800004);                                // D
    @(negedge clk);
    check_cnt++; if (out_low[12:0] !== 13'h0003) $display("FAIL bp_order_c: got l%h want l0003", out_low[12:0]); else pass_cnt++;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_cnt++; if (out_low[12:0] !== 13'h0004) $display("FAIL bp_order_d: got l%h want l0004", out_low[12:0]); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_mode = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h40000000);
    next_cycle();
    in_data = mk(32'h40400000);
    next_cycle();
    in_data = mk(32'h40800000);
    @(negedge clk);
    check_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL rs_full: got v%b r%b want v1 r0", out_valid, in_ready); else pass_cnt++;
    next_cycle();
    rst_n = 1'b0;                                              // in_valid stays 1: must be ignored
    next_cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    exp_q.delete();                                            // in-flight beats are discarded
    @(negedge clk);
    check_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rs_flags: got v%b r%b want v0 r1", out_valid, in_ready); else pass_cnt++;
    check_cnt++; if (act_beat !== '0) $display("FAIL rs_data: got %h want 0", act_beat); else pass_cnt++;
    next_cycle();
    out_ready = 1'b1;
    apply(mk(32'hC0000000), 1'b0);
    check_cnt++;
    if ({out_valid, out_sign[0], out_exp[7:0], out_high[12:0]} !== {1'b1, 1'b1, 8'h80, 13'h0400})
      $display("FAIL rs_new_beat: got v%b s%b e%h h%h want v1 s1 e80 h0400", out_valid, out_sign[0], out_exp[7:0], out_high[12:0]);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_random_stream();
    logic acc;
    int   guard;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      next_cycle();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_mode  = $urandom_range(0, 1);
        for (int i = 0; i < LANES; i++) in_data[i*32 +: 32] = rnd_lane(in_mode);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    next_cycle();
    if (!acc) begin
      // finish a pending transfer so valid is never withdrawn early
      guard = 0;
      while (!(in_ready) && guard < 10) begin next_cycle(); guard++; end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin next_cycle(); guard++; end
    check_cnt++; if (exp_q.size() != 0) $display("FAIL rnd_drain: %0d beats left, want 0", exp_q.size()); else pass_cnt++;
  endtask

  // ---------------- main ----------------
  initial begin
    check_cnt = 0; pass_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single_1p5();
    test_half_neg1();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    test_random_stream();
    next_cycle();
    check_cnt++; if (exp_q.size() != 0) $display("FAIL final_queue: %0d beats left, want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
